// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU interface and the 16-bit sequencer:
// ALU opcodes, flag bit positions and the 16-bit operation encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;
  localparam logic [3:0] ALU_CP  = 4'b0111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'b00,
    OP_ADDSP = 2'b01,
    OP_INC16 = 2'b10,
    OP_DEC16 = 2'b11
  } op_e;

  // High byte of an 8-bit signed displacement sign-extended to 16 bits.
  function automatic logic [7:0] sext_hi_byte(input logic [7:0] e8);
    return e8[7] ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/alu16_seq.sv
// Sequences a 16-bit ADD/ADDSP/INC/DEC as two passes (low byte, then high
// byte with carry) through an external shared 8-bit ALU.
module alu16_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [3:0]  fin,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_fin,
  output logic [3:0]  alu_control,
  input  logic [7:0]  alu_y,
  input  logic [3:0]  alu_fout,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [15:0] result,
  output logic [3:0]  fout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LO   = 2'b01,
    S_HI   = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;

  op_e         r_op;
  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [3:0]  r_fin;
  logic        r_cy_lo;
  logic        r_h_lo;

  logic        r_start_ready;
  logic        r_done_valid;
  logic [15:0] r_result;
  logic [3:0]  r_fout;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [3:0]  r_alu_fin;
  logic [3:0]  r_alu_control;

  logic        w_accept;
  op_e         w_op_src;
  logic [15:0] w_opa_src;
  logic [15:0] w_opb_src;
  logic        w_cy_src;
  logic [7:0]  w_alu_a;
  logic [7:0]  w_alu_b;
  logic [3:0]  w_alu_fin;
  logic [3:0]  w_alu_control;
  logic [3:0]  w_fout_hi;

  assign w_accept = (r_state == S_IDLE) && start_valid;

  // ALU drives are registered, so they are computed from the state being
  // entered and from the operand values that will be latched at this edge.
  assign w_op_src  = w_accept ? op_e'(op) : r_op;
  assign w_opa_src = w_accept ? opa : r_opa;
  assign w_opb_src = w_accept ? opb : r_opb;
  assign w_cy_src  = (r_state == S_LO) ? alu_fout[FLAG_C] : r_cy_lo;

  // Next-state logic; done_ready only counts once done_valid is visible.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_LO;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LO:   w_state_nxt = S_HI;
      S_HI:   w_state_nxt = S_DONE;
      S_DONE: begin
        if (done_ready && r_done_valid) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ALU operand/opcode selection for the byte step being entered.
  always_comb begin
    w_alu_a       = 8'h00;
    w_alu_b       = 8'h00;
    w_alu_fin     = 4'b0000;
    w_alu_control = ALU_CP;
    case (w_state_nxt)
      S_LO: begin
        w_alu_a = w_opa_src[7:0];
        case (w_op_src)
          OP_ADD16, OP_ADDSP: begin
            w_alu_b       = w_opb_src[7:0];
            w_alu_control = ALU_ADD;
          end
          OP_INC16: begin
            w_alu_b       = 8'h01;
            w_alu_control = ALU_ADD;
          end
          OP_DEC16: begin
            w_alu_b       = 8'h01;
            w_alu_control = ALU_SUB;
          end
          default: begin
            w_alu_b       = 8'h00;
            w_alu_control = ALU_CP;
          end
        endcase
      end
      S_HI: begin
        w_alu_a   = w_opa_src[15:8];
        w_alu_fin = {3'b000, w_cy_src};
        case (w_op_src)
          OP_ADD16: begin
            w_alu_b       = w_opb_src[15:8];
            w_alu_control = ALU_ADC;
          end
          OP_ADDSP: begin
            w_alu_b       = sext_hi_byte(w_opb_src[7:0]);
            w_alu_control = ALU_ADC;
          end
          OP_INC16: begin
            w_alu_b       = 8'h00;
            w_alu_control = ALU_ADC;
          end
          OP_DEC16: begin
            w_alu_b       = 8'h00;
            w_alu_control = ALU_SBC;
          end
          default: begin
            w_alu_b       = 8'h00;
            w_alu_control = ALU_CP;
          end
        endcase
      end
      default: begin
        w_alu_a       = 8'h00;
        w_alu_b       = 8'h00;
        w_alu_fin     = 4'b0000;
        w_alu_control = ALU_CP;
      end
    endcase
  end

  // Final flags at the end of the high-byte step; ADDSP keeps low-byte flags.
  always_comb begin
    w_fout_hi = r_fin;
    case (r_op)
      OP_ADD16: w_fout_hi = {r_fin[FLAG_Z], 1'b0, alu_fout[FLAG_H], alu_fout[FLAG_C]};
      OP_ADDSP: w_fout_hi = {1'b0, 1'b0, r_h_lo, r_cy_lo};
      OP_INC16: w_fout_hi = r_fin;
      OP_DEC16: w_fout_hi = r_fin;
      default:  w_fout_hi = r_fin;
    endcase
  end

  // State register and registered handshake/ALU outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_start_ready <= 1'b1;
      r_done_valid  <= 1'b0;
      r_alu_a       <= 8'h00;
      r_alu_b       <= 8'h00;
      r_alu_fin     <= 4'b0000;
      r_alu_control <= ALU_CP;
    end else begin
      r_state       <= w_state_nxt;
      r_start_ready <= (w_state_nxt == S_IDLE);
      r_done_valid  <= (r_state == S_DONE) && (w_state_nxt == S_DONE);
      r_alu_a       <= w_alu_a;
      r_alu_b       <= w_alu_b;
      r_alu_fin     <= w_alu_fin;
      r_alu_control <= w_alu_control;
    end
  end

  // Request capture, per-byte result collection and flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_ADD16;
      r_opa    <= 16'h0000;
      r_opb    <= 16'h0000;
      r_fin    <= 4'b0000;
      r_cy_lo  <= 1'b0;
      r_h_lo   <= 1'b0;
      r_result <= 16'h0000;
      r_fout   <= 4'b0000;
    end else begin
      if (w_accept) begin
        r_op  <= op_e'(op);
        r_opa <= opa;
        r_opb <= opb;
        r_fin <= fin;
      end
      if (r_state == S_LO) begin
        r_result[7:0] <= alu_y;
        r_cy_lo       <= alu_fout[FLAG_C];
        r_h_lo        <= alu_fout[FLAG_H];
      end
      if (r_state == S_HI) begin
        r_result[15:8] <= alu_y;
        r_fout         <= w_fout_hi;
      end
    end
  end

  assign start_ready = r_start_ready;
  assign done_valid  = r_done_valid;
  assign result      = r_result;
  assign fout        = r_fout;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_fin     = r_alu_fin;
  assign alu_control = r_alu_control;

endmodule

// File: tb/tb_alu16_seq.sv
// Self-checking bench for alu16_seq: includes a behavioural 8-bit ALU and a
// 16-bit arithmetic reference model.
module tb_alu16_seq;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [3:0]  fin;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_fin;
  logic [3:0]  alu_control;
  logic [7:0]  alu_y;
  logic [3:0]  alu_fout;
  logic        done_valid;
  logic        done_ready;
  logic [15:0] result;
  logic [3:0]  fout;

  int vectors;
  int miscompares;

  alu16_seq dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .opa(opa), .opb(opb), .fin(fin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fin(alu_fin), .alu_control(alu_control),
    .alu_y(alu_y), .alu_fout(alu_fout),
    .done_valid(done_valid), .done_ready(done_ready),
    .result(result), .fout(fout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit ALU: flags {Z,N,H,C}, C = carry out / borrow, H = nibble carry / borrow.
  logic [8:0] m_t;
  logic       m_h;
  logic       m_n;
  always_comb begin
    m_t = 9'd0;
    m_h = 1'b0;
    m_n = 1'b0;
    case (alu_control)
      4'b0000: begin
        m_t = {1'b0, alu_a} + {1'b0, alu_b};
        m_h = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]}) > 5'd15;
      end
      4'b0001: begin
        m_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_fin[0]};
        m_h = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, alu_fin[0]}) > 5'd15;
      end
      4'b0010: begin
        m_t = {1'b0, alu_a} - {1'b0, alu_b};
        m_h = alu_a[3:0] < alu_b[3:0];
        m_n = 1'b1;
      end
      4'b0011: begin
        m_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_fin[0]};
        m_h = {1'b0, alu_a[3:0]} < ({1'b0, alu_b[3:0]} + {4'd0, alu_fin[0]});
        m_n = 1'b1;
      end
      default: begin
        m_t = {1'b0, alu_a};
        m_h = alu_a[3:0] < alu_b[3:0];
        m_n = 1'b1;
      end
    endcase
    alu_y    = m_t[7:0];
    alu_fout = {(m_t[7:0] == 8'h00), m_n, m_h, m_t[8]};
  end

  // Reference: whole 16-bit arithmetic, flags from the rules per operation.
  function automatic logic [19:0] ref_model(input logic [1:0] o, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] f);
    logic [16:0] s;
    logic [15:0] e;
    logic        h;
    logic        c;
    case (o)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        h = ({1'b0, a[11:0]} + {1'b0, b[11:0]}) > 13'h0FFF;
        return {s[15:0], f[3], 1'b0, h, s[16]};
      end
      2'b01: begin
        e = {{8{b[7]}}, b[7:0]};
        s = {1'b0, a} + {1'b0, e};
        h = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
        c = ({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255;
        return {s[15:0], 2'b00, h, c};
      end
      2'b10:   return {a + 16'd1, f};
      default: return {a - 16'd1, f};
    endcase
  endfunction

  // Stimulus only: issue one request, wait for done, record, then consume it.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, output logic [15:0] res, output logic [3:0] fo,
                       output int lat, output logic [3:0] c_lo, output logic [3:0] c_hi);
    int n;
    n = 0;
    while (!start_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    op = o; opa = a; opb = b; fin = f; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); fin = 4'($urandom);
    c_lo = alu_control;
    c_hi = 4'b0000;
    lat = 0;
    while (!done_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (lat == 1) c_hi = alu_control;
    end
    res = result;
    fo  = fout;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
  endtask

  task automatic test_reset;
    vectors++; if (start_ready !== 1'b1) begin miscompares++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
    vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL reset_done_valid got %b want 0", done_valid); end
    vectors++; if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result got %h want 0000", result); end
    vectors++; if (fout !== 4'b0000) begin miscompares++; $display("FAIL reset_fout got %b want 0000", fout); end
    vectors++; if (alu_control !== 4'b0111) begin miscompares++; $display("FAIL reset_alu_control got %b want 0111", alu_control); end
    vectors++; if ({alu_a, alu_b, alu_fin} !== 20'h00000) begin miscompares++; $display("FAIL reset_alu_operands got %h/%h/%b want 00/00/0000", alu_a, alu_b, alu_fin); end
  endtask

  task automatic test_directed;
    logic [15:0] r;
    logic [3:0]  fo, cl, ch;
    int          lat;
    do_op(2'b00, 16'h0FFF, 16'h0001, 4'b1000, r, fo, lat, cl, ch);
    vectors++; if (r !== 16'h1000) begin miscompares++; $display("FAIL add16_result got %h want 1000", r); end
    vectors++; if (fo !== 4'b1010) begin miscompares++; $display("FAIL add16_fout got %b want 1010", fo); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL add16_latency got %0d want 3", lat); end
    vectors++; if ({cl, ch} !== 8'b0000_0001) begin miscompares++; $display("FAIL add16_ctrl got %b/%b want 0000/0001", cl, ch); end
    do_op(2'b01, 16'hFFF8, 16'h0008, 4'b1111, r, fo, lat, cl, ch);
    vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL addsp_result got %h want 0000", r); end
    vectors++; if (fo !== 4'b0011) begin miscompares++; $display("FAIL addsp_fout got %b want 0011", fo); end
    do_op(2'b10, 16'hFFFF, 16'h1234, 4'b0101, r, fo, lat, cl, ch);
    vectors++; if (r !== 16'h0000) begin miscompares++; $display("FAIL inc16_result got %h want 0000", r); end
    vectors++; if (fo !== 4'b0101) begin miscompares++; $display("FAIL inc16_fout got %b want 0101", fo); end
    vectors++; if ({cl, ch} !== 8'b0000_0001) begin miscompares++; $display("FAIL inc16_ctrl got %b/%b want 0000/0001", cl, ch); end
    do_op(2'b11, 16'h0000, 16'hABCD, 4'b0101, r, fo, lat, cl, ch);
    vectors++; if (r !== 16'hFFFF) begin miscompares++; $display("FAIL dec16_result got %h want FFFF", r); end
    vectors++; if (fo !== 4'b0101) begin miscompares++; $display("FAIL dec16_fout got %b want 0101", fo); end
    vectors++; if ({cl, ch} !== 8'b0010_0011) begin miscompares++; $display("FAIL dec16_ctrl got %b/%b want 0010/0011", cl, ch); end
  endtask

  task automatic test_random;
    logic [15:0] r, a, b;
    logic [3:0]  fo, f, cl, ch;
    logic [1:0]  o;
    logic [19:0] exp;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom); a = 16'($urandom); b = 16'($urandom); f = 4'($urandom);
      exp = ref_model(o, a, b, f);
      do_op(o, a, b, f, r, fo, lat, cl, ch);
      vectors++; if ({r, fo} !== exp) begin miscompares++; $display("FAIL random_%0d op=%b a=%h b=%h fin=%b got %h/%b want %h/%b", i, o, a, b, f, r, fo, exp[19:4], exp[3:0]); end
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL random_latency_%0d got %0d want 3", i, lat); end
    end
  endtask

  task automatic test_hold;
    logic [19:0] exp;
    int          n;
    exp = ref_model(2'b00, 16'h12F0, 16'h0E20, 4'b0110);
    op = 2'b00; opa = 16'h12F0; opb = 16'h0E20; fin = 4'b0110; start_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!done_valid && n < 20) begin
      start_valid = 1'($urandom); done_ready = 1'($urandom);
      op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); fin = 4'($urandom);
      @(posedge clk); #1; n++;
    end
    done_ready = 1'b0;
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL hold_latency got %0d want 3", n); end
    for (int k = 0; k < 5; k++) begin
      start_valid = 1'($urandom); opa = 16'($urandom);
      @(posedge clk); #1;
      vectors++; if ({done_valid, start_ready, result, fout} !== {1'b1, 1'b0, exp}) begin miscompares++; $display("FAIL hold_stable_%0d got v=%b rdy=%b %h/%b want v=1 rdy=0 %h/%b", k, done_valid, start_ready, result, fout, exp[19:4], exp[3:0]); end
    end
    start_valid = 1'b1; done_ready = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; done_ready = 1'b0;
    vectors++; if ({done_valid, start_ready} !== 2'b01) begin miscompares++; $display("FAIL hold_release got v=%b rdy=%b want v=0 rdy=1", done_valid, start_ready); end
    repeat (4) @(posedge clk); #1;
    vectors++; if ({done_valid, start_ready} !== 2'b01) begin miscompares++; $display("FAIL hold_no_phantom got v=%b rdy=%b want v=0 rdy=1", done_valid, start_ready); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] r;
    logic [3:0]  fo, cl, ch;
    logic [19:0] exp;
    int          lat;
    op = 2'b00; opa = 16'hFFFF; opb = 16'hFFFF; fin = 4'b1111; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp = ref_model(2'b01, 16'h8000, 16'h00F0, 4'b1010);
    do_op(2'b01, 16'h8000, 16'h00F0, 4'b1010, r, fo, lat, cl, ch);
    vectors++; if ({r, fo} !== exp) begin miscompares++; $display("FAIL post_reset_op got %h/%b want %h/%b", r, fo, exp[19:4], exp[3:0]); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL post_reset_latency got %0d want 3", lat); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start_valid = 1'b0;
    done_ready = 1'b0;
    op = 2'b00; opa = 16'h0000; opb = 16'h0000; fin = 4'b0000;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
